// File: rtl/fe_ctl_mq_if.sv
`default_nettype none
// ============================================================================
// Module   : fe_ctl_mq_if
// Purpose  : Fetch-buffer request/response, redirect and decode bundle for
//            the fetch controller.
// Revision : 1.0
// ============================================================================
interface fe_ctl_mq_if #(
  parameter int PADDR_W  = 32,
  parameter int INSTR_W  = 32,
  parameter int FQ_DEPTH = 8
);
  localparam int ID_W = $clog2(FQ_DEPTH);

  logic               fe_fb_req_valid;
  logic [PADDR_W-1:0] fe_fb_req_addr;
  logic [ID_W-1:0]    fe_fb_req_id;
  logic               fb_fe_req_ready;
  logic               fb_fe_rsp_valid;
  logic [ID_W-1:0]    fb_fe_rsp_id;
  logic [INSTR_W-1:0] fb_fe_rsp_instr;
  logic               br_mispred_valid;
  logic [PADDR_W-1:0] br_mispred_target;
  logic               nuke_valid;
  logic [PADDR_W-1:0] nuke_target;
  logic               valid_fe1;
  logic [PADDR_W-1:0] instr_fe1_pc;
  logic [INSTR_W-1:0] instr_fe1_instr;
  logic               stall;

  modport master (
    output fe_fb_req_valid, fe_fb_req_addr, fe_fb_req_id,
           valid_fe1, instr_fe1_pc, instr_fe1_instr,
    input  fb_fe_req_ready, fb_fe_rsp_valid, fb_fe_rsp_id, fb_fe_rsp_instr,
           br_mispred_valid, br_mispred_target, nuke_valid, nuke_target, stall
  );

  modport slave (
    input  fe_fb_req_valid, fe_fb_req_addr, fe_fb_req_id,
           valid_fe1, instr_fe1_pc, instr_fe1_instr,
    output fb_fe_req_ready, fb_fe_rsp_valid, fb_fe_rsp_id, fb_fe_rsp_instr,
           br_mispred_valid, br_mispred_target, nuke_valid, nuke_target, stall
  );
endinterface
`default_nettype wire

// File: rtl/fe_ctl_mq.sv
`default_nettype none
// ============================================================================
// Module   : fe_ctl_mq
// Purpose  : Multi-outstanding fetch controller with tagged out-of-order
//            responses, in-order delivery to decode and redirect draining.
// Revision : 1.0
// ============================================================================
module fe_ctl_mq #(
  parameter int PADDR_W  = 32,
  parameter int INSTR_W  = 32,
  parameter int FQ_DEPTH = 8,
  parameter int N_OUTST  = 4
) (
  input wire clk,
  input wire reset,
  fe_ctl_mq_if.master bus
);
  localparam int ID_W  = $clog2(FQ_DEPTH);
  localparam int CNT_W = $clog2(N_OUTST + 1);
  localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(N_OUTST);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    FE_IDLE  = 2'd0,
    FE_RUN   = 2'd1,
    FE_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PADDR_W-1:0]  pc_q, pc_d;
  logic [ID_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [FQ_DEPTH-1:0] alloc_q, alloc_d, rdy_q, rdy_d;
  logic [PADDR_W-1:0]  slot_pc_q [FQ_DEPTH];
  logic [PADDR_W-1:0]  slot_pc_d [FQ_DEPTH];
  logic [INSTR_W-1:0]  slot_instr_q [FQ_DEPTH];
  logic [INSTR_W-1:0]  slot_instr_d [FQ_DEPTH];
  logic [CNT_W-1:0]    inflight_q, inflight_d, drain_cnt_q, drain_cnt_d;

  logic               redirect, req_valid, req_fire, out_valid, pop, rsp_keep;
  logic [PADDR_W-1:0] redir_pc;
  logic [CNT_W-1:0]   arrive;

  always_comb begin
    redirect  = bus.nuke_valid | bus.br_mispred_valid;
    redir_pc  = bus.nuke_valid ? bus.nuke_target : bus.br_mispred_target;
    arrive    = bus.fb_fe_rsp_valid ? ONE : '0;
    req_valid = (state_q == FE_RUN) && !redirect && (inflight_q < MAX_OUT) && !alloc_q[tail_q];
    req_fire  = req_valid && bus.fb_fe_req_ready;
    out_valid = (state_q == FE_RUN) && !redirect && alloc_q[head_q] && rdy_q[head_q];
    pop       = out_valid && !bus.stall;
    rsp_keep  = bus.fb_fe_rsp_valid && (state_q == FE_RUN) && !redirect;

    pc_d         = pc_q;
    head_d       = head_q;
    tail_d       = tail_q;
    alloc_d      = alloc_q;
    rdy_d        = rdy_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;
    inflight_d   = inflight_q;
    drain_cnt_d  = drain_cnt_q;

    if (redirect) begin
      pc_d        = redir_pc;
      head_d      = '0;
      tail_d      = '0;
      alloc_d     = '0;
      rdy_d       = '0;
      inflight_d  = '0;
      // Everything still in flight becomes stale; a redirect while draining adds to the backlog.
      drain_cnt_d = drain_cnt_q + inflight_q - arrive;
    end else begin
      if (state_q == FE_DRAIN && bus.fb_fe_rsp_valid) begin
        drain_cnt_d = drain_cnt_q - ONE;
      end
      if (rsp_keep) begin
        rdy_d[bus.fb_fe_rsp_id]        = 1'b1;
        slot_instr_d[bus.fb_fe_rsp_id] = bus.fb_fe_rsp_instr;
      end
      if (req_fire) begin
        alloc_d[tail_q]   = 1'b1;
        rdy_d[tail_q]     = 1'b0;
        slot_pc_d[tail_q] = pc_q;
        tail_d            = tail_q + 1'b1;
        pc_d              = pc_q + PADDR_W'(4);
      end
      if (pop) begin
        alloc_d[head_q] = 1'b0;
        rdy_d[head_q]   = 1'b0;
        head_d          = head_q + 1'b1;
      end
      inflight_d = inflight_q + (req_fire ? ONE : '0) - (rsp_keep ? ONE : '0);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FE_IDLE:  state_d = FE_RUN;
      FE_RUN:   if (redirect && (inflight_q != arrive)) state_d = FE_DRAIN;
      FE_DRAIN: if (!redirect && (drain_cnt_d == '0)) state_d = FE_RUN;
      default:  state_d = FE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= FE_IDLE;
      pc_q         <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      alloc_q      <= '0;
      rdy_q        <= '0;
      slot_pc_q    <= '{default: '0};
      slot_instr_q <= '{default: '0};
      inflight_q   <= '0;
      drain_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      alloc_q      <= alloc_d;
      rdy_q        <= rdy_d;
      slot_pc_q    <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
      inflight_q   <= inflight_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

  // Outputs are forced quiet while reset is asserted, even before the first edge.
  assign bus.fe_fb_req_valid = reset & req_valid;
  assign bus.fe_fb_req_addr  = reset ? pc_q : '0;
  assign bus.fe_fb_req_id    = reset ? tail_q : '0;
  assign bus.valid_fe1       = reset & out_valid;
  assign bus.instr_fe1_pc    = (reset && out_valid) ? slot_pc_q[head_q] : '0;
  assign bus.instr_fe1_instr = (reset && out_valid) ? slot_instr_q[head_q] : '0;

  a_rsp_unalloc: assert property (@(posedge clk) disable iff (!reset)
    !(bus.fb_fe_rsp_valid && state_q == FE_RUN && !alloc_q[bus.fb_fe_rsp_id]));
  a_drain_underflow: assert property (@(posedge clk) disable iff (!reset)
    !(bus.fb_fe_rsp_valid && state_q == FE_DRAIN && !redirect && drain_cnt_q == '0));
  a_inflight_max: assert property (@(posedge clk) disable iff (!reset)
    inflight_q <= MAX_OUT);
endmodule
`default_nettype wire

// File: tb/tb_fe_ctl_mq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fe_ctl_mq
// Purpose  : Directed self-checking bench for the fetch controller.
// Revision : 1.0
// ============================================================================
module tb_fe_ctl_mq;
  localparam logic [31:0] K = 32'hC0DE_0000;

  typedef struct packed {
    logic [2:0]  id;
    logic [31:0] instr;
    int          due;
  } rsp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fe_ctl_mq_if #(.PADDR_W(32), .INSTR_W(32), .FQ_DEPTH(8)) bus ();

  fe_ctl_mq #(.PADDR_W(32), .INSTR_W(32), .FQ_DEPTH(8), .N_OUTST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int outstanding = 0;
  rsp_t pend[$];

  logic        s_req, s_vld;
  logic [31:0] s_addr, s_pc, s_instr;
  logic [2:0]  s_id;

  task automatic clear_inputs();
    bus.fb_fe_req_ready   = 1'b0;
    bus.fb_fe_rsp_valid   = 1'b0;
    bus.fb_fe_rsp_id      = '0;
    bus.fb_fe_rsp_instr   = '0;
    bus.br_mispred_valid  = 1'b0;
    bus.br_mispred_target = '0;
    bus.nuke_valid        = 1'b0;
    bus.nuke_target       = '0;
    bus.stall             = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    pend.delete();
    outstanding = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One cycle: drive inputs after the falling edge, sample outputs 1ns later.
  task automatic env_cycle(input logic stall_v, input logic ready_v, input logic auto_v,
                           input logic man_v, input logic [2:0] man_id, input logic [31:0] man_instr,
                           input logic br_v, input logic [31:0] br_t,
                           input logic nk_v, input logic [31:0] nk_t);
    @(negedge clk);
    bus.stall             = stall_v;
    bus.fb_fe_req_ready   = ready_v;
    bus.br_mispred_valid  = br_v;
    bus.br_mispred_target = br_t;
    bus.nuke_valid        = nk_v;
    bus.nuke_target       = nk_t;
    bus.fb_fe_rsp_valid   = 1'b0;
    bus.fb_fe_rsp_id      = '0;
    bus.fb_fe_rsp_instr   = '0;
    if (man_v) begin
      bus.fb_fe_rsp_valid = 1'b1;
      bus.fb_fe_rsp_id    = man_id;
      bus.fb_fe_rsp_instr = man_instr;
    end else if (auto_v && pend.size() > 0 && pend[0].due <= cyc) begin
      bus.fb_fe_rsp_valid = 1'b1;
      bus.fb_fe_rsp_id    = pend[0].id;
      bus.fb_fe_rsp_instr = pend[0].instr;
      void'(pend.pop_front());
      outstanding--;
    end
    #1;
    s_req   = bus.fe_fb_req_valid;
    s_addr  = bus.fe_fb_req_addr;
    s_id    = bus.fe_fb_req_id;
    s_vld   = bus.valid_fe1;
    s_pc    = bus.instr_fe1_pc;
    s_instr = bus.instr_fe1_instr;
    if (auto_v && s_req && ready_v) begin
      pend.push_back('{id: s_id, instr: s_addr ^ K, due: cyc + 2});
      outstanding++;
    end
    cyc++;
  endtask

  task automatic run(input logic stall_v, input logic ready_v);
    env_cycle(stall_v, ready_v, 1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic run_man(input logic ready_v, input logic man_v, input logic [2:0] id,
                         input logic [31:0] instr);
    env_cycle(1'b0, ready_v, 1'b0, man_v, id, instr, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.fe_fb_req_valid, bus.fe_fb_req_addr, bus.fe_fb_req_id, bus.valid_fe1,
         bus.instr_fe1_pc, bus.instr_fe1_instr} !== '0) begin
      n_bad++; $display("FAIL reset_held outputs not zero req_v=%b addr=%h v=%b", bus.fe_fb_req_valid, bus.fe_fb_req_addr, bus.valid_fe1);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.fe_fb_req_valid !== 1'b0 || bus.valid_fe1 !== 1'b0) begin
      n_bad++; $display("FAIL reset_first_cycle req_v=%b v=%b expected 0 0", bus.fe_fb_req_valid, bus.valid_fe1);
    end
    run(1'b0, 1'b0);
    n_cmp++;
    if (s_req !== 1'b1 || s_addr !== 32'h0 || s_id !== 3'd0) begin
      n_bad++; $display("FAIL reset_first_req got v=%b addr=%h id=%0d expected 1 0 0", s_req, s_addr, s_id);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr = 32'h0, exp_pc = 32'h0;
    logic [2:0]  exp_id = 3'd0;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      run(1'b0, 1'b1);
      if (s_req) begin
        n_cmp++;
        if (s_addr !== exp_addr || s_id !== exp_id) begin
          n_bad++; $display("FAIL stream_req i=%0d got addr=%h id=%0d expected %h %0d", i, s_addr, s_id, exp_addr, exp_id);
        end
        exp_addr = exp_addr + 32'd4;
        exp_id   = exp_id + 3'd1;
      end
      if (i >= 3) begin
        n_cmp++;
        if (s_vld !== 1'b1 || s_pc !== exp_pc || s_instr !== (exp_pc ^ K)) begin
          n_bad++; $display("FAIL stream_out i=%0d got v=%b pc=%h instr=%h expected pc %h", i, s_vld, s_pc, s_instr, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
      end
      n_cmp++;
      if (outstanding > 4) begin
        n_bad++; $display("FAIL stream_inflight i=%0d got %0d expected <= 4", i, outstanding);
      end
    end
  endtask

  task automatic test_stall_full();
    int fires = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      run(1'b1, 1'b1);
      if (s_req) fires++;
      if (i >= 3) begin
        n_cmp++;
        if (s_vld !== 1'b1 || s_pc !== 32'h0 || s_instr !== K) begin
          n_bad++; $display("FAIL stall_hold i=%0d got v=%b pc=%h instr=%h expected 1 0 %h", i, s_vld, s_pc, s_instr, K);
        end
      end
    end
    n_cmp++;
    if (fires != 8) begin
      n_bad++; $display("FAIL stall_req_count got %0d expected 8", fires);
    end
    for (int i = 0; i < 8; i++) begin
      run(1'b0, 1'b1);
      n_cmp++;
      if (s_vld !== 1'b1 || s_pc !== 32'(4 * i) || s_instr !== (32'(4 * i) ^ K)) begin
        n_bad++; $display("FAIL stall_release i=%0d got v=%b pc=%h expected pc %h", i, s_vld, s_pc, 32'(4 * i));
      end
      if (i == 0) begin
        n_cmp++;
        if (s_req !== 1'b0) begin
          n_bad++; $display("FAIL full_same_cycle_reuse got req_v=%b expected 0", s_req);
        end
      end
      if (i == 1) begin
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h20 || s_id !== 3'd0) begin
          n_bad++; $display("FAIL full_next_cycle_reuse got v=%b addr=%h id=%0d expected 1 20 0", s_req, s_addr, s_id);
        end
      end
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_man(1'b1, 1'b0, 3'd0, 32'd0);
      n_cmp++;
      if (s_req !== 1'b1 || s_addr !== 32'(4 * i) || s_id !== 3'(i)) begin
        n_bad++; $display("FAIL ooo_req i=%0d got v=%b addr=%h id=%0d", i, s_req, s_addr, s_id);
      end
    end
    run_man(1'b0, 1'b1, 3'd2, 32'h8 ^ K);
    n_cmp++;
    if (s_vld !== 1'b0) begin n_bad++; $display("FAIL ooo_wait_id2 got v=%b expected 0", s_vld); end
    run_man(1'b0, 1'b1, 3'd0, 32'h0 ^ K);
    n_cmp++;
    if (s_vld !== 1'b0) begin n_bad++; $display("FAIL ooo_wait_id0 got v=%b expected 0", s_vld); end
    for (int i = 0; i < 3; i++) begin
      run_man(1'b0, (i == 0), 3'd1, 32'h4 ^ K);
      n_cmp++;
      if (s_vld !== 1'b1 || s_pc !== 32'(4 * i) || s_instr !== (32'(4 * i) ^ K)) begin
        n_bad++; $display("FAIL ooo_deliver i=%0d got v=%b pc=%h instr=%h expected pc %h", i, s_vld, s_pc, s_instr, 32'(4 * i));
      end
    end
    run_man(1'b0, 1'b0, 3'd0, 32'd0);
    n_cmp++;
    if (s_vld !== 1'b0) begin n_bad++; $display("FAIL ooo_empty got v=%b expected 0", s_vld); end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 4; i++) run_man(1'b1, (i == 3), 3'd0, K);
    env_cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 32'h100, 1'b0, 32'd0);
    n_cmp++;
    if (s_vld !== 1'b0 || s_req !== 1'b0) begin
      n_bad++; $display("FAIL mispred_cycle got v=%b req_v=%b expected 0 0", s_vld, s_req);
    end
    for (int i = 1; i < 4; i++) begin
      run_man(1'b1, 1'b1, 3'(i), 32'hDEAD_0000);
      n_cmp++;
      if (s_req !== 1'b0 || s_vld !== 1'b0) begin
        n_bad++; $display("FAIL drain_quiet i=%0d got req_v=%b v=%b expected 0 0", i, s_req, s_vld);
      end
    end
    run_man(1'b1, 1'b0, 3'd0, 32'd0);
    n_cmp++;
    if (s_req !== 1'b1 || s_addr !== 32'h100 || s_id !== 3'd0 || s_vld !== 1'b0) begin
      n_bad++; $display("FAIL mispred_restart got v=%b addr=%h id=%0d out_v=%b expected 1 100 0 0", s_req, s_addr, s_id, s_vld);
    end
  endtask

  task automatic test_nuke_priority();
    do_reset();
    env_cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 32'h300, 1'b1, 32'h200);
    n_cmp++;
    if (s_req !== 1'b0) begin n_bad++; $display("FAIL nuke_cycle got req_v=%b expected 0", s_req); end
    run_man(1'b1, 1'b0, 3'd0, 32'd0);
    n_cmp++;
    if (s_req !== 1'b1 || s_addr !== 32'h200 || s_id !== 3'd0) begin
      n_bad++; $display("FAIL nuke_priority got v=%b addr=%h id=%0d expected 1 200 0", s_req, s_addr, s_id);
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    for (int i = 0; i < 2; i++) run_man(1'b1, 1'b0, 3'd0, 32'd0);
    env_cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 32'h40, 1'b0, 32'd0);
    run_man(1'b1, 1'b0, 3'd0, 32'd0);
    n_cmp++;
    if (s_req !== 1'b0) begin n_bad++; $display("FAIL drain_entered got req_v=%b expected 0", s_req); end
    do_reset();
    run_man(1'b1, 1'b0, 3'd0, 32'd0);
    n_cmp++;
    if (s_req !== 1'b1 || s_addr !== 32'h0 || s_id !== 3'd0 || s_vld !== 1'b0) begin
      n_bad++; $display("FAIL reset_from_drain got v=%b addr=%h id=%0d out_v=%b expected 1 0 0 0", s_req, s_addr, s_id, s_vld);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_stream();
    test_stall_full();
    test_out_of_order();
    test_mispredict();
    test_nuke_priority();
    test_reset_in_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fe_ctl_mq.md
Name: fe_ctl_mq

Overview:
- Next-generation fetch controller. Keeps up to N_OUTST fetch-buffer requests in flight, tags each with a slot ID, and writes possibly out-of-order responses into a FQ_DEPTH-entry fetch queue.
- Delivers instructions to decode in program order, one per cycle, under a decode stall.
- Flushes on branch mispredict or nuke, redirects the PC, and drains stale in-flight responses before fetching again.
- Sits between the fetch buffer and decode.

Parameters:
PADDR_W, 32, physical address / PC width
INSTR_W, 32, instruction width
FQ_DEPTH, 8, fetch queue entries; power of 2, >= 2
N_OUTST, 4, max in-flight requests; 1 <= N_OUTST <= FQ_DEPTH
ID_W, $clog2(FQ_DEPTH), request/response tag width (derived)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-low (0 = reset)
fe_fb_req_valid  out  1  fetch request valid
fe_fb_req_addr  out  PADDR_W  fetch address
fe_fb_req_id  out  ID_W  fetch queue slot tag
fb_fe_req_ready  in  1  fetch buffer accepts request this cycle
fb_fe_rsp_valid  in  1  response valid
fb_fe_rsp_id  in  ID_W  tag of the response
fb_fe_rsp_instr  in  INSTR_W  fetched instruction
br_mispred_valid  in  1  mispredict redirect
br_mispred_target  in  PADDR_W  mispredict target
nuke_valid  in  1  nuke redirect
nuke_target  in  PADDR_W  nuke restart PC
valid_fe1  out  1  instruction valid to decode
instr_fe1_pc  out  PADDR_W  PC of delivered instruction
instr_fe1_instr  out  INSTR_W  delivered instruction
stall  in  1  decode stall; holds the output

Behaviour:
- Reset (reset==0 at posedge):
  - PC=0, state=FE_IDLE.
  - head=tail=0, all slot alloc/ready bits=0.
  - inflight=0, drain_cnt=0.
  - Outputs are 0 while reset is held and in the first cycle after reset.
- States:
  - FE_IDLE -> FE_RUN after one cycle.
  - FE_RUN -> FE_DRAIN on redirect when inflight > 0 (counted after this cycle's responses).
  - FE_DRAIN -> FE_RUN when drain_cnt reaches 0.
  - Redirect in FE_RUN with inflight == 0 stays in FE_RUN.
  - Reset mid-operation from any state returns to FE_IDLE and discards everything.
- Redirect:
  - redirect = nuke_valid | br_mispred_valid. nuke wins: PC <= nuke_target, otherwise PC <= br_mispred_target.
  - All slots are cleared and head=tail=0. drain_cnt <= inflight - (in-flight responses arriving this cycle); inflight <= 0.
  - A redirect in FE_DRAIN also updates the PC and stays in FE_DRAIN; drain_cnt accumulates.
- Request rule:
  - fe_fb_req_valid = state==FE_RUN & ~redirect & inflight < N_OUTST & slot[tail] not allocated.
  - addr = PC, id = tail.
  - On accept (valid & ready): slot[tail] is allocated, tail++ mod FQ_DEPTH, inflight++, PC += 4 (wraps mod 2^PADDR_W).
- Response:
  - In FE_DRAIN, or in a redirect cycle, every response is dropped and decrements drain_cnt (not in a redirect cycle).
  - Otherwise, slot[id] stores the instruction and its PC (PC is captured at request time), ready is set, and inflight--.
  - Responses may return in any order.
  - A request accepted and a response returned in the same cycle leave inflight unchanged.
- Output:
  - valid_fe1 = slot[head] allocated & ready & ~redirect & state==FE_RUN. Data comes from slot[head].
  - Pop when valid_fe1 & ~stall: the slot is freed and head++.
  - While stall is held, valid and data are stable.
  - A slot whose response is outstanding blocks younger ready slots (in-order delivery).
- Full/empty:
  - The queue is full when all slots are allocated; issue stops.
  - A slot freed by a pop is reusable by a request in the next cycle, not the same cycle.
- Assertions:
  - Response to an unallocated slot while in FE_RUN.
  - drain_cnt underflow.
  - inflight > N_OUTST.

Test Plan:
- Release reset, ready=1, responses 2 cycles later in order, stall=0 -> requests for PCs 0x0, 0x4, 0x8, ...; after fill, valid_fe1 every cycle with matching PCs; inflight never exceeds 4.
- Hold stall=1 for 20 cycles -> exactly 8 requests issued (queue full); instr_fe1 stable at PC 0x0; after release, PCs 0x0..0x1C delivered consecutively.
- Responses for ids 2, 0, 1 in that order -> no output until id 0 returns; then PCs 0x0, 0x4, 0x8 delivered in order.
- br_mispred_valid with target 0x100 while 3 requests are in flight -> valid_fe1=0 that cycle; 3 stale responses dropped in FE_DRAIN; next request addr 0x100, id 0.
- nuke (target 0x200) and br_mispred (target 0x300) in the same cycle -> next request addr 0x200.
- reset=0 while in FE_DRAIN with drain_cnt=2 -> all state cleared; after release, first request addr 0x0, no assertion fires.
